// File: rtl/irq_pkg.sv
// Shared constants, register offsets and FSM state type for the interrupt controller.
package irq_pkg;
  localparam int NUM_IRQ = 32;
  localparam int VEC_W   = 5;
  localparam int NUM_GRP = NUM_IRQ / 2;

  localparam logic [3:0]  PRI_OFS   = 4'd0;
  localparam logic [3:0]  ENA_OFS   = 4'd4;
  localparam logic [3:0]  ACT_OFS   = 4'd8;
  localparam logic [23:0] WIN_BYTES = 24'd12;

  typedef logic [1:0] irq_pri_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Sources 2g and 2g+1 share the 2-bit priority field of group g.
  function automatic irq_pri_t grp_pri_of(input logic [2*NUM_GRP-1:0] pri_bits, input int src);
    return pri_bits[2*(src/2) +: 2];
  endfunction
endpackage

// File: rtl/irq_controller_if.sv
// Bus-slave and CPU request/acknowledge signals of the interrupt controller.
interface irq_controller_if;
  import irq_pkg::*;

  logic             bus_write;
  logic             bus_read;
  logic [23:0]      bus_address_in;
  logic [7:0]       bus_data_in;
  logic [7:0]       bus_data_out;
  irq_pri_t         cpu_ilevel;
  logic             irq_ack;
  logic             irq_req;
  logic [VEC_W-1:0] irq_vector;
  irq_pri_t         irq_level;

  modport slave (
    input  bus_write, bus_read, bus_address_in, bus_data_in, cpu_ilevel, irq_ack,
    output bus_data_out, irq_req, irq_vector, irq_level
  );

  modport master (
    output bus_write, bus_read, bus_address_in, bus_data_in, cpu_ilevel, irq_ack,
    input  bus_data_out, irq_req, irq_vector, irq_level
  );
endinterface

// File: rtl/irq_arbiter.sv
// Combinational arbiter: highest priority candidate above cpu_ilevel wins, ties to lowest index.
module irq_arbiter
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0] act,
  input  logic [NUM_IRQ-1:0] ena,
  input  irq_pri_t           pri_src [NUM_IRQ],
  input  irq_pri_t           cpu_ilevel,
  output logic               any_valid,
  output logic [VEC_W-1:0]   winner_idx,
  output irq_pri_t           winner_level
);

  // Scanning downwards with >= lets the lower index take an equal-priority tie.
  always_comb begin
    any_valid    = 1'b0;
    winner_idx   = '0;
    winner_level = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (act[i] && ena[i] && (pri_src[i] != 2'd0) && (pri_src[i] > cpu_ilevel) &&
          (pri_src[i] >= winner_level)) begin
        any_valid    = 1'b1;
        winner_idx   = VEC_W'(i);
        winner_level = pri_src[i];
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pulse capture, PRI/ENA/ACT register window, arbitration, CPU handshake.
// Build option IRQ_AUTOCLEAR_EN: the accepted ack clears the served ACT flag in hardware.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [23:0] IRQ_BASE = 24'h002020
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_ce_cpu,
  input  logic [NUM_IRQ-1:0] irq_in,
  irq_controller_if.slave    bus
);

  logic [23:0]        ofs_full;
  logic               in_win;
  logic [3:0]         ofs;
  logic               wr_en;
  logic               ack_take;
  logic [7:0]         rd_data;

  logic [31:0]        pri_q, pri_d;
  logic [31:0]        ena_q, ena_d;
  logic [31:0]        act_q, act_d;

  irq_state_e         state_q, state_d;
  logic               irq_req_q, irq_req_d;
  logic [VEC_W-1:0]   irq_vector_q, irq_vector_d;
  irq_pri_t           irq_level_q, irq_level_d;

  irq_pri_t           pri_src [NUM_IRQ];
  logic               win_valid;
  logic [VEC_W-1:0]   win_idx;
  irq_pri_t           win_lvl;
  logic [NUM_IRQ-1:0] held_mask;
  logic               held_any;
  logic [VEC_W-1:0]   held_idx;
  irq_pri_t           held_lvl;
  logic               held_valid;

  // Unsigned offset wraps for addresses below the base, so one compare bounds the window.
  assign ofs_full = bus.bus_address_in - IRQ_BASE;
  assign in_win   = ofs_full < WIN_BYTES;
  assign ofs      = ofs_full[3:0];
  assign wr_en    = bus.bus_write & clk_ce_cpu & in_win;
  assign ack_take = clk_ce_cpu & bus.irq_ack & (state_q == REQUEST);

  always_comb begin
    pri_d = pri_q;
    ena_d = ena_q;
    act_d = act_q;
    if (wr_en) begin
      if (ofs[3:2] == PRI_OFS[3:2]) begin
        pri_d[{ofs[1:0], 3'b000} +: 8] = bus.bus_data_in;
      end else if (ofs[3:2] == ENA_OFS[3:2]) begin
        ena_d[{ofs[1:0], 3'b000} +: 8] = bus.bus_data_in;
      end else if (ofs[3:2] == ACT_OFS[3:2]) begin
        act_d[{ofs[1:0], 3'b000} +: 8] = act_q[{ofs[1:0], 3'b000} +: 8] & ~bus.bus_data_in;
      end
    end
`ifdef IRQ_AUTOCLEAR_EN
    if (ack_take) begin
      act_d[irq_vector_q] = 1'b0;
    end
`endif
    // Capture is applied last so a new pulse always beats any clear in the same cycle.
    act_d = act_d | irq_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pri_q <= '0;
      ena_q <= '0;
      act_q <= '0;
    end else begin
      pri_q <= pri_d;
      ena_q <= ena_d;
      act_q <= act_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.bus_read && in_win) begin
      if (ofs[3:2] == PRI_OFS[3:2]) begin
        rd_data = pri_q[{ofs[1:0], 3'b000} +: 8];
      end else if (ofs[3:2] == ENA_OFS[3:2]) begin
        rd_data = ena_q[{ofs[1:0], 3'b000} +: 8];
      end else if (ofs[3:2] == ACT_OFS[3:2]) begin
        rd_data = act_q[{ofs[1:0], 3'b000} +: 8];
      end
    end
  end

  assign bus.bus_data_out = rd_data;

  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      pri_src[i] = grp_pri_of(pri_q, i);
    end
  end

  irq_arbiter u_arb (
    .act          (act_q),
    .ena          (ena_q),
    .pri_src      (pri_src),
    .cpu_ilevel   (bus.cpu_ilevel),
    .any_valid    (win_valid),
    .winner_idx   (win_idx),
    .winner_level (win_lvl)
  );

  // Same arbiter restricted to the held source tells whether it is still a candidate.
  assign held_mask = NUM_IRQ'(1) << irq_vector_q;

  irq_arbiter u_held (
    .act          (act_q & held_mask),
    .ena          (ena_q),
    .pri_src      (pri_src),
    .cpu_ilevel   (bus.cpu_ilevel),
    .any_valid    (held_any),
    .winner_idx   (held_idx),
    .winner_level (held_lvl)
  );

  assign held_valid = held_any & (held_idx == irq_vector_q) & (held_lvl != 2'd0);

  always_comb begin
    state_d      = state_q;
    irq_req_d    = irq_req_q;
    irq_vector_d = irq_vector_q;
    irq_level_d  = irq_level_q;
    if (clk_ce_cpu) begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_d      = REQUEST;
            irq_req_d    = 1'b1;
            irq_vector_d = win_idx;
            irq_level_d  = win_lvl;
          end
        end
        REQUEST: begin
          if (ack_take) begin
            state_d   = SERVICE;
            irq_req_d = 1'b0;
          end else if (!held_valid) begin
            state_d   = IDLE;
            irq_req_d = 1'b0;
          end
        end
        SERVICE: begin
          // Wait for the flag to clear so the same source is not requested twice.
          if (!act_q[irq_vector_q]) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          irq_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_req_q    <= 1'b0;
      irq_vector_q <= '0;
      irq_level_q  <= '0;
    end else begin
      state_q      <= state_d;
      irq_req_q    <= irq_req_d;
      irq_vector_q <= irq_vector_d;
      irq_level_q  <= irq_level_d;
    end
  end

  assign bus.irq_req    = irq_req_q;
  assign bus.irq_vector = irq_vector_q;
  assign bus.irq_level  = irq_level_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: directed scenarios plus randomized rounds vs a reference model.
module tb_irq_controller;
  import irq_pkg::*;

  localparam logic [23:0] BASE = 24'h002020;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_ce_cpu;
  logic [NUM_IRQ-1:0] irq_in;

  irq_controller_if bus ();

  irq_controller #(.IRQ_BASE(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_ce_cpu (clk_ce_cpu),
    .irq_in     (irq_in),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_pri [4];
  logic [31:0] m_ena;
  logic [31:0] m_act;
  int          m_ilevel;

  // Scoreboard
  logic [6:0] req_q [$];
  logic [7:0] rd_q [$];
  int n_chk = 0;
  int n_fail = 0;
  int req_cnt = 0;
  logic prev_req = 1'b0;

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  function automatic void flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endfunction

  function automatic int gpri(input int s);
    int g;
    g = s / 2;
    return int'((m_pri[g/4] >> ((g % 4) * 2)) & 8'h03);
  endfunction

  // Returns src*4+level of the expected winner, or -1 when nothing qualifies.
  function automatic int model_winner();
    for (int lvl = 3; lvl >= 1; lvl--) begin
      if (lvl <= m_ilevel) return -1;
      for (int s = 0; s < NUM_IRQ; s++) begin
        if (m_act[s] && m_ena[s] && gpri(s) == lvl) return s * 4 + lvl;
      end
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_rd(input logic [23:0] a);
    logic [23:0] o;
    int k;
    o = a - BASE;
    k = int'(o[1:0]);
    if (o < 24'd4) return m_pri[k];
    else if (o < 24'd8) return m_ena[8*k +: 8];
    else if (o < 24'd12) return m_act[8*k +: 8];
    return 8'h00;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) m_pri[k] = 8'h00;
    m_ena = '0;
    m_act = '0;
  endfunction

  // Monitor: reads and rising requests are popped from the scoreboard queues.
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.bus_read) begin
        if (rd_q.size() == 0) flag("rd_unexpected");
        else check("rd_data", 32'(bus.bus_data_out), 32'(rd_q.pop_front()));
      end
      if (bus.irq_req && !prev_req) begin
        req_cnt++;
        if (req_q.size() == 0) begin
          flag($sformatf("req_unexpected vector %0d level %0d", bus.irq_vector, bus.irq_level));
        end else begin
          e = req_q.pop_front();
          check("req_vector", 32'(bus.irq_vector), 32'(e[6:2]));
          check("req_level", 32'(bus.irq_level), 32'(e[1:0]));
        end
      end
      prev_req = bus.irq_req;
    end
  end

  initial begin
    clk_ce_cpu = 1'b1;
    forever begin
      @(negedge clk);
      clk_ce_cpu = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wr(input logic [23:0] a, input logic [7:0] d, input logic [31:0] pulse = '0);
    logic [23:0] o;
    int k;
    @(negedge clk);
    bus.bus_write = 1'b1;
    bus.bus_address_in = a;
    bus.bus_data_in = d;
    irq_in = pulse;
    @(posedge clk);
    while (!clk_ce_cpu) @(posedge clk);
    o = a - BASE;
    k = int'(o[1:0]);
    if (o < 24'd4) m_pri[k] = d;
    else if (o < 24'd8) m_ena[8*k +: 8] = d;
    else if (o < 24'd12) m_act[8*k +: 8] = m_act[8*k +: 8] & ~d;
    m_act = m_act | pulse;
    @(negedge clk);
    bus.bus_write = 1'b0;
    irq_in = '0;
  endtask

  task automatic rd_model(input logic [23:0] a);
    @(negedge clk);
    bus.bus_read = 1'b1;
    bus.bus_address_in = a;
    rd_q.push_back(model_rd(a));
    @(negedge clk);
    bus.bus_read = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] m);
    @(negedge clk);
    irq_in = m;
    m_act = m_act | m;
    @(negedge clk);
    irq_in = '0;
  endtask

  task automatic ack(input int src);
    @(negedge clk);
    bus.irq_ack = 1'b1;
    @(posedge clk);
    while (!clk_ce_cpu) @(posedge clk);
`ifdef IRQ_AUTOCLEAR_EN
    m_act[src] = 1'b0;
`else
    if (src < 0) m_act = m_act;
`endif
    @(negedge clk);
    bus.irq_ack = 1'b0;
  endtask

  task automatic wait_req(input int start);
    int n;
    n = 0;
    while (req_cnt == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (req_cnt == start) begin
      flag("req_timeout");
      if (req_q.size() != 0) void'(req_q.pop_front());
    end
  endtask

  task automatic check_no_req(input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (bus.irq_req) seen = 1'b1;
    end
    check("no_req", 32'(seen), 32'd0);
  endtask

  task automatic set_ilevel(input int l);
    @(negedge clk);
    m_ilevel = l;
    bus.cpu_ilevel = 2'(l);
  endtask

  task automatic serve_all();
    int w, start, s;
    for (int guard = 0; guard < 40; guard++) begin
      w = model_winner();
      if (w < 0) break;
      s = w / 4;
      start = req_cnt;
      req_q.push_back(7'(w));
      wait_req(start);
      ack(s);
      check("req_drop_after_ack", 32'(bus.irq_req), 32'd0);
`ifndef IRQ_AUTOCLEAR_EN
      wr(BASE + 24'(8 + s / 8), 8'(1 << (s % 8)));
`endif
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < 4; k++) wr(BASE + 24'(8 + k), 8'hFF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, n;
    logic [31:0] m;
    reset = 1'b1;
    irq_in = '0;
    bus.bus_write = 1'b0;
    bus.bus_read = 1'b0;
    bus.bus_address_in = '0;
    bus.bus_data_in = '0;
    bus.cpu_ilevel = '0;
    bus.irq_ack = 1'b0;
    m_ilevel = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_req", 32'(bus.irq_req), 32'd0);
    check("rst_vector", 32'(bus.irq_vector), 32'd0);
    check("rst_level", 32'(bus.irq_level), 32'd0);
    for (int a = 0; a < 12; a++) rd_model(BASE + 24'(a));
    rd_model(BASE + 24'd12);
    rd_model(BASE - 24'd1);

    // Basic request / ack / W1C
    wr(BASE + 24'd0, 8'h03);
    wr(BASE + 24'd4, 8'h01);
    start = req_cnt;
    req_q.push_back({5'd0, 2'd3});
    pulse(32'h1);
    wait_req(start);
    ack(0);
    check("basic_drop", 32'(bus.irq_req), 32'd0);
    rd_model(BASE + 24'd8);
    wr(BASE + 24'd8, 8'h01);
    rd_model(BASE + 24'd8);
    check_no_req(10);

    // Arbitration: two pulses on one clock
    wr(BASE + 24'd0, 8'h1D);
    wr(BASE + 24'd4, 8'h0F);
    pulse(32'h9);
    serve_all();
    clear_all();

    // Tie-break and CPU level mask
    wr(BASE + 24'd0, 8'h20);
    wr(BASE + 24'd4, 8'h30);
    set_ilevel(2);
    pulse(32'h30);
    check_no_req(20);
    set_ilevel(1);
    serve_all();
    clear_all();
    set_ilevel(0);

    // Withdrawal by disabling the held source, then re-issue
    wr(BASE + 24'd0, 8'h03);
    wr(BASE + 24'd4, 8'h01);
    start = req_cnt;
    req_q.push_back({5'd0, 2'd3});
    pulse(32'h1);
    wait_req(start);
    wr(BASE + 24'd4, 8'h00);
    n = 0;
    while (bus.irq_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("withdraw_drop", 32'(bus.irq_req), 32'd0);
    check_no_req(10);
    start = req_cnt;
    req_q.push_back({5'd0, 2'd3});
    wr(BASE + 24'd4, 8'h01);
    wait_req(start);
    ack(0);
    wr(BASE + 24'd8, 8'h01);
    clear_all();

    // Set/clear collision on ACT[7]
    wr(BASE + 24'd4, 8'h00);
    pulse(32'h80);
    rd_model(BASE + 24'd8);
    wr(BASE + 24'd8, 8'h80, 32'h80);
    rd_model(BASE + 24'd8);
    wr(BASE + 24'd8, 8'h80);
    rd_model(BASE + 24'd8);

    // Reset while a request is outstanding
    wr(BASE + 24'd1, 8'hC0);
    wr(BASE + 24'd5, 8'h40);
    start = req_cnt;
    req_q.push_back({5'd14, 2'd3});
    pulse(32'h1 << 14);
    wait_req(start);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("midrst_req", 32'(bus.irq_req), 32'd0);
    check("midrst_vector", 32'(bus.irq_vector), 32'd0);
    check("midrst_level", 32'(bus.irq_level), 32'd0);
    for (int a = 0; a < 12; a++) rd_model(BASE + 24'(a));

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < 4; k++) begin
        wr(BASE + 24'(k), 8'($urandom));
        wr(BASE + 24'(4 + k), 8'($urandom));
      end
      set_ilevel(int'($urandom_range(0, 3)));
      m = '0;
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) m[$urandom_range(0, 31)] = 1'b1;
      pulse(m);
      serve_all();
      rd_model(BASE + 24'($urandom_range(0, 11)));
      rd_model(BASE + 24'(8 + $urandom_range(0, 3)));
      clear_all();
      rd_model(BASE + 24'(8 + $urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    if (req_q.size() != 0) flag("req_queue_not_empty");
    if (rd_q.size() != 0) flag("rd_queue_not_empty");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
